// File: rtl/adder4_bist_pkg.sv
// Shared types and sizing helpers for the adder4_bist self-test controller.
// state_t : controller FSM encoding (IDLE, SETTLE, CHECK, DONE).
// VEC_W / CNT_W : vector and error-counter widths for the default 4-bit adder.
package adder4_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int VEC_W     = 2 * DEF_WIDTH + 1;
  localparam int CNT_W     = VEC_W + 1;

  // {a,b,ci} width for an arbitrary operand width.
  function automatic int vec_width(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/adder4_bist.sv
// Built-in self-test controller for a WIDTH-bit adder: sweeps every {a,b,ci},
// compares {co,s} against a golden sum, counts mismatches and records the first.
// Ports: clk/rst_n/start in; a/b/ci out to adder; s/co in from adder;
//        busy/done/pass/error_count/first_fail status out.
import adder4_bist_pkg::*;

module adder4_bist #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  output logic                 ci,
  input  logic [WIDTH-1:0]     s,
  input  logic                 co,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   error_count,
  output logic [2*WIDTH:0]     first_fail
);

  localparam int VW  = vec_width(WIDTH);
  localparam int CW  = VW + 1;
  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);

  state_t          state_q, state_d;
  logic [VW-1:0]   vec_q, vec_d;
  logic [SCW-1:0]  scnt_q, scnt_d;
  logic [CW-1:0]   err_q, err_d;
  logic [VW-1:0]   ff_q, ff_d;

  logic [WIDTH:0]  expected;
  logic            mismatch;

  // Operands come straight from the vector register, so they are glitch-free.
  assign {a, b, ci} = vec_q;

  assign expected = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
  // Only meaningful in CHECK; s/co may be X elsewhere.
  assign mismatch = ({co, s} != expected);

  assign busy        = (state_q == SETTLE) || (state_q == CHECK);
  assign done        = (state_q == DONE);
  assign pass        = (state_q == DONE) && (err_q == '0);
  assign error_count = err_q;
  assign first_fail  = ff_q;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    scnt_d  = scnt_q;
    err_d   = err_q;
    ff_d    = ff_q;
    unique case (state_q)
      IDLE, DONE: begin
        // Level-sensitive: a run starts on the first sampled start=1.
        if (start) begin
          state_d = SETTLE;
          vec_d   = '0;
          scnt_d  = SETTLE_LOAD;
          err_d   = '0;
          ff_d    = '0;
        end
      end
      SETTLE: begin
        if (scnt_q == '0) state_d = CHECK;
        else              scnt_d  = scnt_q - SCW'(1);
      end
      CHECK: begin
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + CW'(1);
          if (err_q == '0) ff_d  = vec_q;
        end
        // The last vector exits to DONE so vec never wraps silently.
        if (vec_q == '1) begin
          state_d = DONE;
        end else begin
          vec_d   = vec_q + VW'(1);
          scnt_d  = SETTLE_LOAD;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      scnt_q  <= '0;
      err_q   <= '0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      scnt_q  <= scnt_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
    end
  end

endmodule

// File: tb/tb_adder4_bist.sv
// Bench for adder4_bist: a behavioural 4-bit adder with selectable stuck-at
// faults sits beside the controller; table rows give fault and expected results.
module tb_adder4_bist;
  import adder4_bist_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  a, b;
  logic        ci;
  logic [3:0]  s;
  logic        co;
  logic        busy, done, pass;
  logic [9:0]  error_count;
  logic [8:0]  first_fail;

  int          fault;
  logic [4:0]  true_sum;

  int compared;
  int mismatched;

  adder4_bist #(.WIDTH(4), .SETTLE_CYCLES(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .ci          (ci),
    .s           (s),
    .co          (co),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .error_count (error_count),
    .first_fail  (first_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder under test with fault injection.
  always_comb begin
    true_sum = {1'b0, a} + {1'b0, b} + {4'b0, ci};
    s  = true_sum[3:0];
    co = true_sum[4];
    case (fault)
      1: s[0] = 1'b0;
      2: co   = 1'b0;
      3: s[3] = 1'b1;
      4: begin s = ~true_sum[3:0]; co = ~true_sum[4]; end
      default: ;
    endcase
  end

  typedef struct {
    string      name;
    int         fault;
    logic       exp_pass;
    logic [9:0] exp_err;
    logic [8:0] exp_ff;
  } row_t;

  row_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts clock edges after the start edge until done is seen; optionally
  // re-pulses start mid-run to confirm it is ignored.
  task automatic wait_done(input bit repulse, output int cycles);
    cycles = 0;
    while (!done && cycles < 2000) begin
      start = repulse && (cycles == 10 || cycles == 500);
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    if (!done) begin
      mismatched++;
      compared++;
      $display("FAIL timeout: done not seen within %0d cycles", cycles);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    compared   = 0;
    mismatched = 0;
    fault      = 0;
    rst_n      = 1'b0;
    start      = 1'b0;

    // s[0] is wrong whenever the true sum is odd: half of 512 vectors.
    // co is wrong for 120 (ci=0) + 136 (ci=1) carrying vectors; first is 0+15+1.
    // s[3] forced high: by the t <-> 31-t symmetry exactly half have bit3=0, vec 0 first.
    tbl[0] = '{"golden", 0, 1'b1, 10'd0,   9'd0};
    tbl[1] = '{"s0_sa0", 1, 1'b0, 10'd256, 9'b0000_0000_1};
    tbl[2] = '{"co_sa0", 2, 1'b0, 10'd256, {4'd0, 4'd15, 1'b1}};
    tbl[3] = '{"s3_sa1", 3, 1'b0, 10'd256, 9'd0};
    tbl[4] = '{"all_inv", 4, 1'b0, 10'd512, 9'd0};

    do_reset();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_pass", 32'(pass), 32'd0);
    chk("reset_vec",  32'({a, b, ci}), 32'd0);
    chk("reset_err",  32'(error_count), 32'd0);
    chk("reset_ff",   32'(first_fail), 32'd0);

    foreach (tbl[i]) begin
      fault = tbl[i].fault;
      do_reset();
      pulse_start();
      chk({tbl[i].name, "_busy"}, 32'(busy), 32'd1);
      wait_done(1'b0, cyc);
      chk({tbl[i].name, "_cycles"}, 32'(cyc), 32'd1024);
      chk({tbl[i].name, "_pass"}, 32'(pass), 32'(tbl[i].exp_pass));
      chk({tbl[i].name, "_err"}, 32'(error_count), 32'(tbl[i].exp_err));
      chk({tbl[i].name, "_ff"}, 32'(first_fail), 32'(tbl[i].exp_ff));
      chk({tbl[i].name, "_idle"}, 32'(busy), 32'd0);
    end

    // DONE holds status and the last vector.
    repeat (5) @(negedge clk);
    chk("done_hold", 32'(done), 32'd1);
    chk("last_vec", 32'({a, b, ci}), 32'h1FF);

    // Restart after a failing run on a now-golden adder.
    fault = 0;
    pulse_start();
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_err",  32'(error_count), 32'd0);
    chk("restart_ff",   32'(first_fail), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    wait_done(1'b0, cyc);
    chk("restart_cycles", 32'(cyc), 32'd1024);
    chk("restart_pass", 32'(pass), 32'd1);

    // Start pulses while busy are ignored.
    fault = 1;
    pulse_start();
    wait_done(1'b1, cyc);
    chk("repulse_cycles", 32'(cyc), 32'd1024);
    chk("repulse_err", 32'(error_count), 32'd256);

    // Async reset mid-run with accumulated errors.
    pulse_start();
    repeat (300) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_err_nonzero", 32'(error_count != 0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_vec",  32'({a, b, ci}), 32'd0);
    chk("arst_err",  32'(error_count), 32'd0);
    chk("arst_ff",   32'(first_fail), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fault = 0;
    @(negedge clk);
    chk("post_arst_idle", 32'(busy), 32'd0);
    pulse_start();
    wait_done(1'b0, cyc);
    chk("post_arst_cycles", 32'(cyc), 32'd1024);
    chk("post_arst_pass", 32'(pass), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
